// File: rtl/tqvp_htfab_duty_scan.sv
// Duty-meter channel scheduler: walks the enabled channels, discards settling windows,
// captures one duty result per channel into a register bank readable over the TinyQV bus.
module tqvp_htfab_duty_scan #(
  parameter int NUM_CH     = 8,
  parameter int SETTLE_WIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] meas_channel,
  input  logic       meas_window_done,
  input  logic [7:0] meas_duty,
  output logic       scan_irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_CAPTURE, S_ADVANCE
  } state_t;

  state_t      state_q;
  logic [7:0]  result_q [NUM_CH];
  logic        run_q;
  logic        oneshot_q;
  logic [7:0]  mask_q;
  logic [7:0]  fresh_q;
  logic        sweep_done_q;
  logic [2:0]  meas_channel_q;
  logic [2:0]  start_q;
  logic [1:0]  settle_q;

  logic [2:0]  sel_ch;
  logic        has_sel;
  logic        has_above;
  logic        abort;
  logic        busy;

  assign busy         = (state_q != S_IDLE);
  assign abort        = data_write && (address == 4'd8) && !data_in[0];
  assign meas_channel = meas_channel_q;
  assign scan_irq     = sweep_done_q;

  // Next channel: lowest enabled index at or after start_q, wrapping through 7 -> 0.
  always_comb begin
    sel_ch    = start_q;
    has_sel   = 1'b0;
    has_above = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!has_sel && mask_q[start_q + 3'(i)]) begin
        sel_ch  = start_q + 3'(i);
        has_sel = 1'b1;
      end
      if ((3'(i) > meas_channel_q) && mask_q[i]) begin
        has_above = 1'b1;
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (address < 4'd8) begin
      data_out = result_q[address[2:0]];
    end else begin
      case (address)
        4'd8:    data_out = {6'b0, oneshot_q, run_q};
        4'd9:    data_out = mask_q;
        4'd10:   data_out = {|fresh_q, meas_channel_q, 2'b00, busy, sweep_done_q};
        4'd11:   data_out = fresh_q;
        default: data_out = 8'h00;
      endcase
    end
  end

  // Software writes come first so hardware sets of FRESH/SWEEP_DONE/RUN later in this block win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= 8'h00;
      run_q          <= 1'b0;
      oneshot_q      <= 1'b0;
      mask_q         <= 8'hFF;
      fresh_q        <= 8'h00;
      sweep_done_q   <= 1'b0;
      meas_channel_q <= 3'd0;
      start_q        <= 3'd0;
      settle_q       <= 2'd0;
    end else begin
      if (data_write) begin
        case (address)
          4'd8:    {oneshot_q, run_q} <= data_in[1:0];
          4'd9:    mask_q <= data_in;
          4'd10:   if (data_in[0]) sweep_done_q <= 1'b0;
          4'd11:   fresh_q <= fresh_q & ~data_in;
          default: ;
        endcase
      end

      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_q && (mask_q != 8'h00)) begin
              start_q <= 3'd0;
              state_q <= S_SELECT;
            end
          end
          S_SELECT: begin
            if (!has_sel) begin
              state_q <= S_IDLE;
            end else begin
              meas_channel_q <= sel_ch;
              settle_q       <= 2'(SETTLE_WIN);
              state_q        <= (SETTLE_WIN > 0) ? S_SETTLE : S_CAPTURE;
            end
          end
          S_SETTLE: begin
            if (meas_window_done) begin
              settle_q <= settle_q - 2'd1;
              if (settle_q <= 2'd1) state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (meas_window_done) begin
              result_q[meas_channel_q] <= meas_duty;
              fresh_q[meas_channel_q]  <= 1'b1;
              state_q                  <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (mask_q == 8'h00) begin
              state_q <= S_IDLE;
            end else if (!has_above && oneshot_q) begin
              sweep_done_q <= 1'b1;
              run_q        <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              if (!has_above) sweep_done_q <= 1'b1;
              start_q <= meas_channel_q + 3'd1;
              state_q <= S_SELECT;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tqvp_htfab_duty_scan.sv
// Randomized bench for the duty-meter scan scheduler against a sweep-order reference model.
module tb_tqvp_htfab_duty_scan;

  localparam int SW = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [2:0] meas_channel;
  logic       meas_window_done;
  logic [7:0] meas_duty;
  logic       scan_irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_res [8];
  logic [7:0] exp_fresh;
  logic       exp_sd;
  logic [7:0] rd_val;

  always #5 clk = ~clk;

  tqvp_htfab_duty_scan #(.NUM_CH(8), .SETTLE_WIN(SW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .address          (address),
    .data_write       (data_write),
    .data_in          (data_in),
    .data_out         (data_out),
    .meas_channel     (meas_channel),
    .meas_window_done (meas_window_done),
    .meas_duty        (meas_duty),
    .scan_irq         (scan_irq)
  );

  // Sweep order model: pulse k belongs to the (k / (SW+1))-th enabled channel in ascending
  // cyclic order; the last pulse of each group is the captured one.
  function automatic void model_pulse(input logic [7:0] mask, input int k,
                                      input logic [7:0] duty, output logic [2:0] ch);
    int en[$];
    int pos;
    for (int i = 0; i < 8; i++) if (mask[i]) en.push_back(i);
    pos = k / (SW + 1);
    ch  = 3'(en[pos % en.size()]);
    if ((k % (SW + 1)) == SW) begin
      exp_res[ch]   = duty;
      exp_fresh[ch] = 1'b1;
      if (en[en.size() - 1] == int'(ch)) exp_sd = 1'b1;
    end
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a;
    #1 d = data_out;
  endtask

  task automatic pulse(input logic [7:0] duty);
    @(negedge clk);
    meas_duty = duty; meas_window_done = 1'b1;
    @(negedge clk);
    meas_window_done = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clean();
    wr(4'd10, 8'h01);
    wr(4'd11, 8'hFF);
    exp_fresh = 8'h00;
    exp_sd    = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rexp [4];
    rexp = '{8'h00, 8'hFF, 8'h00, 8'h00};
    rst_n = 1'b0; data_write = 1'b0; address = 4'd0; data_in = 8'h00;
    meas_window_done = 1'b0; meas_duty = 8'h00;
    for (int i = 0; i < 8; i++) exp_res[i] = 8'h00;
    exp_fresh = 8'h00; exp_sd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (meas_channel !== 3'd0) $display("FAIL reset_channel: got %0d expected 0", meas_channel);
    else n_pass++;
    n_checks++;
    if (scan_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", scan_irq);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd(4'(8 + i), rd_val);
      n_checks++;
      if (rd_val !== rexp[i]) $display("FAIL reset_reg%0d: got %h expected %h", 8 + i, rd_val, rexp[i]);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      rd(4'(i), rd_val);
      n_checks++;
      if (rd_val !== 8'h00) $display("FAIL reset_result%0d: got %h expected 00", i, rd_val);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] duties [4];
    logic [2:0] ch;
    duties = '{8'h11, 8'h22, 8'h33, 8'h44};
    clean();
    wr(4'd9, 8'h05);
    wr(4'd8, 8'h03);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      model_pulse(8'h05, k, duties[k], ch);
      n_checks++;
      if (meas_channel !== ch) $display("FAIL oneshot_ch%0d: got %0d expected %0d", k, meas_channel, ch);
      else n_pass++;
      pulse(duties[k]);
    end
    rd(4'd0, rd_val);
    n_checks++;
    if (rd_val !== 8'h22) $display("FAIL oneshot_result0: got %h expected 22", rd_val);
    else n_pass++;
    rd(4'd2, rd_val);
    n_checks++;
    if (rd_val !== 8'h44) $display("FAIL oneshot_result2: got %h expected 44", rd_val);
    else n_pass++;
    rd(4'd11, rd_val);
    n_checks++;
    if (rd_val !== 8'h05) $display("FAIL oneshot_fresh: got %h expected 05", rd_val);
    else n_pass++;
    rd(4'd10, rd_val);
    n_checks++;
    if (rd_val !== 8'hA1) $display("FAIL oneshot_status: got %h expected a1", rd_val);
    else n_pass++;
    rd(4'd8, rd_val);
    n_checks++;
    if (rd_val !== 8'h02) $display("FAIL oneshot_ctrl: got %h expected 02", rd_val);
    else n_pass++;
    n_checks++;
    if (scan_irq !== 1'b1) $display("FAIL oneshot_irq: got %b expected 1", scan_irq);
    else n_pass++;
    pulse(8'h77);
    rd(4'd0, rd_val);
    n_checks++;
    if (rd_val !== exp_res[0]) $display("FAIL idle_pulse_ignored: got %h expected %h", rd_val, exp_res[0]);
    else n_pass++;
  endtask

  task automatic test_continuous();
    logic [2:0] ch;
    logic [7:0] d;
    clean();
    wr(4'd9, 8'h81);
    wr(4'd8, 8'h01);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      model_pulse(8'h81, k, d, ch);
      n_checks++;
      if (meas_channel !== ch) $display("FAIL cont_ch%0d: got %0d expected %0d", k, meas_channel, ch);
      else n_pass++;
      pulse(d);
      if (k == 3 || k == 7) begin
        n_checks++;
        if (scan_irq !== exp_sd) $display("FAIL cont_irq_set%0d: got %b expected %b", k, scan_irq, exp_sd);
        else n_pass++;
        wr(4'd10, 8'h01);
        exp_sd = 1'b0;
        n_checks++;
        if (scan_irq !== exp_sd) $display("FAIL cont_irq_clr%0d: got %b expected %b", k, scan_irq, exp_sd);
        else n_pass++;
      end
    end
    wr(4'd8, 8'h00);
    rd(4'd0, rd_val);
    n_checks++;
    if (rd_val !== exp_res[0]) $display("FAIL cont_result0: got %h expected %h", rd_val, exp_res[0]);
    else n_pass++;
    rd(4'd7, rd_val);
    n_checks++;
    if (rd_val !== exp_res[7]) $display("FAIL cont_result7: got %h expected %h", rd_val, exp_res[7]);
    else n_pass++;
    rd(4'd11, rd_val);
    n_checks++;
    if (rd_val !== exp_fresh) $display("FAIL cont_fresh: got %h expected %h", rd_val, exp_fresh);
    else n_pass++;
  endtask

  task automatic test_random_sweeps();
    logic [7:0] mask;
    logic [7:0] d;
    logic [2:0] ch;
    int         np;
    for (int it = 0; it < 4; it++) begin
      clean();
      mask = 8'($urandom_range(1, 255));
      np   = $urandom_range(2, 12);
      wr(4'd9, mask);
      wr(4'd8, 8'h01);
      repeat (3) @(negedge clk);
      for (int k = 0; k < np; k++) begin
        d = 8'($urandom);
        model_pulse(mask, k, d, ch);
        n_checks++;
        if (meas_channel !== ch)
          $display("FAIL rand%0d_ch%0d: got %0d expected %0d mask %h", it, k, meas_channel, ch, mask);
        else n_pass++;
        pulse(d);
      end
      wr(4'd8, 8'h00);
      for (int i = 0; i < 8; i++) begin
        rd(4'(i), rd_val);
        n_checks++;
        if (rd_val !== exp_res[i]) $display("FAIL rand%0d_result%0d: got %h expected %h", it, i, rd_val, exp_res[i]);
        else n_pass++;
      end
      rd(4'd11, rd_val);
      n_checks++;
      if (rd_val !== exp_fresh) $display("FAIL rand%0d_fresh: got %h expected %h", it, rd_val, exp_fresh);
      else n_pass++;
      rd(4'd10, rd_val);
      n_checks++;
      if (rd_val[1:0] !== {1'b0, exp_sd})
        $display("FAIL rand%0d_busy_done: got %b expected %b", it, rd_val[1:0], {1'b0, exp_sd});
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [2:0] ch;
    clean();
    wr(4'd9, 8'h08);
    wr(4'd8, 8'h01);
    repeat (3) @(negedge clk);
    model_pulse(8'h08, 0, 8'h55, ch);
    n_checks++;
    if (meas_channel !== ch) $display("FAIL abort_ch: got %0d expected %0d", meas_channel, ch);
    else n_pass++;
    pulse(8'h55);
    @(negedge clk);
    meas_duty = 8'h99; meas_window_done = 1'b1;
    address = 4'd8; data_in = 8'h00; data_write = 1'b1;
    @(negedge clk);
    meas_window_done = 1'b0; data_write = 1'b0; address = 4'd10;
    #1;
    n_checks++;
    if (data_out[1] !== 1'b0) $display("FAIL abort_busy: got %b expected 0", data_out[1]);
    else n_pass++;
    rd(4'd3, rd_val);
    n_checks++;
    if (rd_val !== exp_res[3]) $display("FAIL abort_result3: got %h expected %h", rd_val, exp_res[3]);
    else n_pass++;
    rd(4'd11, rd_val);
    n_checks++;
    if (rd_val !== exp_fresh) $display("FAIL abort_fresh: got %h expected %h", rd_val, exp_fresh);
    else n_pass++;
  endtask

  task automatic test_mask_zero();
    clean();
    wr(4'd9, 8'h00);
    wr(4'd8, 8'h01);
    repeat (5) @(negedge clk);
    rd(4'd10, rd_val);
    n_checks++;
    if (rd_val[1] !== 1'b0) $display("FAIL maskzero_busy: got %b expected 0", rd_val[1]);
    else n_pass++;
    wr(4'd9, 8'h10);
    for (int i = 0; i < 2 && meas_channel !== 3'd4; i++) @(negedge clk);
    n_checks++;
    if (meas_channel !== 3'd4) $display("FAIL maskzero_select: got %0d expected 4", meas_channel);
    else n_pass++;
    wr(4'd8, 8'h00);
    wr(4'd9, 8'hFF);
  endtask

  task automatic test_regs();
    wr(4'd3, 8'hAA);
    rd(4'd3, rd_val);
    n_checks++;
    if (rd_val !== exp_res[3]) $display("FAIL ro_result3: got %h expected %h", rd_val, exp_res[3]);
    else n_pass++;
    for (int a = 12; a < 16; a++) begin
      rd(4'(a), rd_val);
      n_checks++;
      if (rd_val !== 8'h00) $display("FAIL unmapped%0d: got %h expected 00", a, rd_val);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_random_sweeps();
    test_abort();
    test_mask_zero();
    test_regs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
